// File: rtl/conv_frame_sequencer.sv
// Sequences column-major pixel words through an external convolver and forwards results once the kernel window is full.
// Convolver strobe is combinational with the accepted beat; output is registered one cycle later and stalls input when held.
module conv_frame_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int WORDS_PER_COL = 50,
    parameter int NUM_COLS      = 200,
    parameter int KERNEL_WIDTH  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic                  o_conv_valid,
    output logic [DATA_WIDTH-1:0] o_conv_data,
    input  logic [DATA_WIDTH-1:0] i_conv_data,
    output logic                  o_conv_clear,
    output logic                  o_frame_done,
    output logic                  o_frame_err
);

    localparam int WW = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   word_cnt;
    logic [CW-1:0]   col_cnt;
    logic            reset_q;
    logic            accept;
    logic            word_last;
    logic            at_final;
    logic            fill_done;
    logic            out_load;

    assign word_last = (word_cnt == WW'(WORDS_PER_COL - 1));
    assign at_final  = word_last & (col_cnt == CW'(NUM_COLS - 1));
    assign fill_done = word_last & (int'(col_cnt) == KERNEL_WIDTH - 2);
    assign out_load  = accept & (int'(col_cnt) >= KERNEL_WIDTH - 1);

    // reset_q keeps the input closed for one extra cycle after reset releases
    assign s_axis_ready = ~i_reset & ~reset_q & (~m_axis_valid | m_axis_ready) &
                          (((state == IDLE) & i_enable) | (state == FILL) | (state == RUN));
    assign accept       = s_axis_valid & s_axis_ready;
    assign o_conv_valid = accept;
    assign o_conv_data  = s_axis_data;
    assign o_conv_clear = (state == FLUSH) & ~i_reset;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ((KERNEL_WIDTH <= 1) || fill_done) ? RUN : FILL;
            FILL: if (accept && fill_done) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        // frame end, normal or early, overrides any fill progress
        if (accept && (at_final || s_axis_last)) state_nxt = FLUSH;
    end

    always_ff @(posedge i_clk) begin
        reset_q <= i_reset;
        if (i_reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            col_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                word_cnt <= '0;
                col_cnt  <= '0;
            end else if (accept) begin
                if (at_final || s_axis_last) begin
                    word_cnt <= '0;
                    col_cnt  <= '0;
                end else if (word_last) begin
                    word_cnt <= '0;
                    col_cnt  <= col_cnt + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_frame_done <= accept & at_final;
            if (out_load) begin
                m_axis_data  <= i_conv_data;
                m_axis_valid <= 1'b1;
                m_axis_last  <= at_final;
            end else if (m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
            // error when the last marker and the final position disagree
            if (accept) begin
                if (state == IDLE) o_frame_err <= 1'b0;
                if (s_axis_last != at_final) o_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a scoreboard of expected output beats.
module tb_conv_frame_sequencer;

    localparam int W = 4;
    localparam int N = 5;
    localparam int K = 3;
    localparam int FRAME = W * N;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        conv_valid;
    logic [31:0] conv_out;
    logic [31:0] conv_in;
    logic        conv_clear;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    int last_cnt = 0;
    int done_cnt = 0;
    logic [32:0] q[$];
    bit   bp_en = 0;
    int   bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;
    bit   prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] conv_f(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign conv_in = conv_f(conv_out);

    conv_frame_sequencer #(.DATA_WIDTH(32), .WORDS_PER_COL(W), .NUM_COLS(N), .KERNEL_WIDTH(K)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
        .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready),
        .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last), .m_axis_ready(m_ready),
        .o_conv_valid(conv_valid), .o_conv_data(conv_out), .i_conv_data(conv_in),
        .o_conv_clear(conv_clear), .o_frame_done(frame_done), .o_frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        failures++;
        $error("FAIL %s bound expired", tag);
    endtask

    // Output side: pops the scoreboard on each handshake and checks hold behaviour under stall.
    always @(negedge clk) begin
        if (i_reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && !m_ready) chk("stall_ready", s_ready, 0);
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    logic [32:0] e;
                    e = q.pop_front();
                    chk("out_data", m_data, e[31:0]);
                    chk("out_last", m_last, e[32]);
                end
                out_cnt++;
                if (m_last) last_cnt++;
            end
            if (frame_done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_en) begin
            m_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic lst, input bit exp_out, input logic exp_last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = lst;
        while (1) begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            step();
            n++;
            if (n > 50) begin
                fail_now("accept_timeout");
                return;
            end
        end
        chk("conv_valid", conv_valid, 1);
        chk("conv_data", conv_out, d);
        if (exp_out) q.push_back({exp_last, conv_f(d)});
        step();
    endtask

    task automatic send_beats(input int nb, input int last_at, input bit tim, input int bp_from, input int drop_at);
        for (int b = 1; b <= nb; b++) begin
            send_beat($urandom, (b == last_at), ((b - 1) / W) >= K - 1, (b == FRAME));
            if (b == 1) chk("err_cleared_first_beat", frame_err, 0);
            if (tim) chk("out_start_timing", m_valid, (b >= (K - 1) * W + 1));
            if (b == bp_from) bp_en = 1;
            if (b == drop_at) i_enable = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        bp_en   = 0;
        m_ready = 1'b1;
    endtask

    task automatic run_frame(input int nb, input int last_at, input bit tim, input int bp_from,
                             input int drop_at, input logic exp_done, input logic exp_err);
        int o0, l0, d0, n;
        o0 = out_cnt;
        l0 = last_cnt;
        d0 = done_cnt;
        send_beats(nb, last_at, tim, bp_from, drop_at);
        chk("done_pulse", frame_done, exp_done);
        chk("flush_clear", conv_clear, 1);
        chk("flush_ready", s_ready, 0);
        chk("frame_err", frame_err, exp_err);
        step();
        chk("done_one_cycle", frame_done, 0);
        chk("clear_one_cycle", conv_clear, 0);
        chk("idle_ready", s_ready, i_enable);
        n = 0;
        while (q.size() != 0 || m_valid) begin
            step();
            n++;
            if (n > 20) begin
                fail_now("drain_timeout");
                break;
            end
        end
        @(negedge clk);
        chk("out_count", out_cnt - o0, (nb > (K - 1) * W) ? nb - (K - 1) * W : 0);
        chk("last_count", last_cnt - l0, (nb == FRAME) ? 1 : 0);
        chk("done_count", done_cnt - d0, exp_done);
        chk("err_sticky", frame_err, exp_err);
        step();
    endtask

    task automatic check_reset_state();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_clear", conv_clear, 0);
    endtask

    task automatic release_reset();
        i_reset  = 1'b0;
        s_valid  = 1'b0;
        i_enable = 1'b1;
        chk("post_rst_ready_low", s_ready, 0);
        step();
        chk("post_rst_ready_high", s_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        repeat (3) step();
        check_reset_state();
        release_reset();

        // nominal frame
        run_frame(FRAME, FRAME, 1, 0, 0, 1'b1, 1'b0);
        // downstream backpressure during RUN
        run_frame(FRAME, FRAME, 0, (K - 1) * W + 1, 0, 1'b1, 1'b0);
        // early last on beat 10, then a clean frame
        run_frame(10, 10, 0, 0, 0, 1'b0, 1'b1);
        run_frame(FRAME, FRAME, 0, 0, 0, 1'b1, 1'b0);
        // missing last on the final beat
        run_frame(FRAME, 0, 0, 0, 0, 1'b1, 1'b1);

        // reset clears a sticky error while idle
        i_reset = 1'b1;
        step();
        check_reset_state();
        release_reset();

        // reset mid-frame while beat 11 is presented
        send_beats(10, 0, 0, 0, 0);
        step();
        chk("pre_reset_queue_empty", q.size(), 0);
        s_valid = 1'b1;
        s_data  = $urandom;
        i_reset = 1'b1;
        step();
        check_reset_state();
        step();
        q.delete();
        release_reset();
        run_frame(FRAME, FRAME, 1, 0, 0, 1'b1, 1'b0);

        // enable low blocks start; dropping it mid-frame does not
        i_enable = 1'b0;
        s_valid  = 1'b1;
        s_data   = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("disabled_ready", s_ready, 0);
            chk("disabled_conv_valid", conv_valid, 0);
            step();
        end
        i_enable = 1'b1;
        run_frame(FRAME, FRAME, 0, 0, 5, 1'b1, 1'b0);
        s_valid = 1'b1;
        @(negedge clk);
        chk("disabled_after_frame", s_ready, 0);
        s_valid  = 1'b0;
        i_enable = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI-Stream word width; each word holds DATA_WIDTH/8 pixels, one column segment.
REQ-002 SHALL have parameter WORDS_PER_COL, default 50: input words per padded image column (IMAGE_HEIGHT 200 / 4 pixels per word).
REQ-003 SHALL have parameter NUM_COLS, default 200: padded columns per input frame.
REQ-004 SHALL have parameter KERNEL_WIDTH, default 3: convolver kernel width; the first KERNEL_WIDTH-1 columns produce no output.
REQ-005 SHALL have ports:
  i_clk  in  1  clock; all logic on the rising edge.
  i_reset  in  1  synchronous reset, active-high.
  i_enable  in  1  permits a new frame to start.
  s_axis_valid  in  1  input beat valid.
  s_axis_data  in  DATA_WIDTH  input pixel word.
  s_axis_last  in  1  marks the last beat of the input frame.
  s_axis_ready  out  1  input beat accepted when high with valid.
  m_axis_valid  out  1  output beat valid.
  m_axis_data  out  DATA_WIDTH  convolved word.
  m_axis_last  out  1  marks the last output beat of the frame.
  m_axis_ready  in  1  downstream ready.
  o_conv_valid  out  1  shift strobe to the convolver.
  o_conv_data  out  DATA_WIDTH  word to the convolver.
  i_conv_data  in  DATA_WIDTH  convolver result for the word strobed this cycle (combinational).
  o_conv_clear  out  1  one-cycle clear of the convolver line buffers.
  o_frame_done  out  1  one-cycle pulse when a frame completes normally.
  o_frame_err  out  1  sticky framing error flag.

Function
REQ-006 SHALL implement the states IDLE, FILL, RUN and FLUSH, with IDLE on reset.
REQ-007 SHALL define accept = s_axis_valid & s_axis_ready; counters word_cnt (0..WORDS_PER_COL-1) and col_cnt (0..NUM_COLS-1) advance only on accept.
REQ-008 SHALL drive s_axis_ready = (~m_axis_valid | m_axis_ready) & ((IDLE & i_enable) | FILL | RUN); s_axis_ready SHALL be 0 in FLUSH.
REQ-009 SHALL drive o_conv_valid = accept and o_conv_data = s_axis_data combinationally, with no extra latency.
REQ-010 On accept in IDLE, SHALL clear o_frame_err, count the beat as word 0 of column 0, and go to FILL; if KERNEL_WIDTH=1, SHALL go directly to RUN.
REQ-011 word_cnt SHALL wrap from WORDS_PER_COL-1 to 0 and increment col_cnt at the same time.
REQ-012 SHALL go from FILL to RUN on the accept that completes column KERNEL_WIDTH-2.
REQ-013 On accept with col_cnt >= KERNEL_WIDTH-1, SHALL register i_conv_data into m_axis_data and set m_axis_valid on the next edge (1-cycle latency); beats in earlier columns SHALL NOT load the output.
REQ-014 m_axis_last SHALL be loaded as 1 only with the word at col_cnt=NUM_COLS-1, word_cnt=WORDS_PER_COL-1, and SHALL be loaded as 0 otherwise.
REQ-015 m_axis_valid SHALL clear when m_axis_ready=1 and no new load occurs; m_axis_data and m_axis_last SHALL hold while valid=1 and ready=0.
REQ-016 On accept of the final position (last column, last word), SHALL go to FLUSH and pulse o_frame_done for one cycle; if s_axis_last=0 on that beat, SHALL also set o_frame_err.
REQ-017 On accept with s_axis_last=1 before the final position, SHALL set o_frame_err, go to FLUSH without pulsing o_frame_done, and reset both counters; a pending output beat SHALL still drain normally.
REQ-018 FLUSH SHALL last exactly one cycle with o_conv_clear=1, then return to IDLE with word_cnt=col_cnt=0; o_conv_clear SHALL be 0 in all other states.
REQ-019 Deasserting i_enable SHALL only block a frame start in IDLE; a frame already in progress SHALL run to completion.
REQ-020 o_frame_err SHALL stay set until the first accept of the next frame, or until reset.

Reset
REQ-021 i_reset=1 at a clock edge SHALL force: state IDLE; counters 0; m_axis_valid, m_axis_last, o_frame_done, o_frame_err 0; m_axis_data 0. This SHALL apply mid-frame and override all other activity.
REQ-022 During and immediately after reset, s_axis_ready and o_conv_clear SHALL be 0 until the edge after i_reset falls.

Verification (WORDS_PER_COL=4, NUM_COLS=5, KERNEL_WIDTH=3)
REQ-023 Nominal frame: 20 beats with continuous valid/ready, s_axis_last on beat 20 -> 12 output beats starting 1 cycle after beat 9, m_axis_last on output 12, o_frame_done 1 cycle after beat 20, o_conv_clear 1 cycle, o_frame_err=0.
REQ-024 Backpressure: m_axis_ready toggled 1,0,0,1 during RUN -> s_axis_ready=0 while output is held; no output word lost or duplicated; data equals i_conv_data sampled at each accept.
REQ-025 Early last: s_axis_last on beat 10 -> o_frame_err=1, no o_frame_done, FLUSH then IDLE; the next 20-beat frame produces 12 correct outputs and clears o_frame_err on its first beat.
REQ-026 Missing last: beat 20 with s_axis_last=0 -> o_frame_done pulse and o_frame_err=1, m_axis_last on output 12.
REQ-027 Reset mid-frame at beat 11 -> all outputs at reset values; the following frame outputs 12 beats with no residue from the aborted frame.
REQ-028 i_enable=0 in IDLE with s_axis_valid=1 -> s_axis_ready=0, no accept; i_enable dropped at beat 5 -> frame completes with all 20 beats.
